// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package riscv_mem_pkg;

    // Arbiter FSM: either free to grant, or waiting out a read's latency.
    typedef enum logic {
        IDLE    = 1'b0,
        RD_BUSY = 1'b1
    } arb_state_t;

    // Requester identity; the encoding doubles as the bit index in req/gnt vectors.
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    // Longest supported read latency and the counter width that holds it.
    localparam int MAX_MEM_LAT = 4;
    localparam int LAT_CNT_W   = 3;

endpackage : riscv_mem_pkg

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-side signals around the port arbiter.
//
// Handshake: a requester raises its req with address (and store data)
// stable and holds it until the arbiter pulses the matching gnt for one
// cycle; the transfer is accepted in that cycle. Read data returns later
// on the rvalid/rdata pair for exactly one cycle, with rdata 0 otherwise.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // Fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Memory port
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_raddr, mem_waddr, mem_wdata, mem_wr
    );

    // Requester/memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_raddr, mem_waddr, mem_wdata, mem_wr
    );

endinterface : mem_port_arbiter_if

// File: rtl/rr_arb2.sv
// Two-way round-robin select. Purely combinational; the caller owns the
// last-grant register and feeds it back in.
module rr_arb2
    import riscv_mem_pkg::*;
(
    input  logic [1:0] req,      // bit 0 = fetch, bit 1 = data
    input  req_id_t    lastGnt,
    output logic [1:0] gnt       // one-hot or zero
);

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (lastGnt == REQ_IF) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule : rr_arb2

// File: rtl/mem_port_arbiter.sv
// Shares the single port of the 64-bit data memory between instruction
// fetch and load/store. One transaction is outstanding at a time; reads
// are tracked with a latency down-counter and returned to their issuer.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output arb_state_t          dbgState
);

    // Out-of-range latencies are pulled into the supported 1..MAX_MEM_LAT window.
    localparam int LAT_USE = (MEM_LAT > MAX_MEM_LAT) ? MAX_MEM_LAT :
                             ((MEM_LAT < 1) ? 1 : MEM_LAT);
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD  = LAT_CNT_W'(LAT_USE);
    localparam logic [LAT_CNT_W-1:0] LAT_LAST  = LAT_CNT_W'(1);
    localparam logic [DATA_W-1:0]    DATA_ZERO = '0;
    localparam logic [ADDR_W-1:0]    ADDR_ZERO = '0;

    arb_state_t           state,   stateNext;
    logic [LAT_CNT_W-1:0] latCnt,  latCntNext;
    req_id_t              owner,   ownerNext;
    req_id_t              lastGnt, lastGntNext;
    logic [ADDR_W-1:0]    addrQ,   addrQNext;

    logic              completing;
    logic              grantWin;
    logic [1:0]        reqVec;
    logic [1:0]        gntVec;
    logic              gntIf;
    logic              gntD;
    logic              isStore;
    logic [ADDR_W-1:0] selAddr;

    // The cycle a read finishes is also a grant window, so back-to-back
    // reads overlap the old rvalid with the new gnt. Reset blocks grants.
    assign completing = (state == RD_BUSY) && (latCnt == LAT_LAST);
    assign grantWin   = !reset && ((state == IDLE) || completing);
    assign reqVec     = grantWin ? {bus.d_req, bus.if_req} : 2'b00;

    rr_arb2 u_rr (
        .req     (reqVec),
        .lastGnt (lastGnt),
        .gnt     (gntVec)
    );

    assign gntIf    = gntVec[REQ_IF];
    assign gntD     = gntVec[REQ_D];
    assign isStore  = gntD && bus.d_we;
    assign selAddr  = gntD ? bus.d_addr : bus.if_addr;
    assign dbgState = state;

    // State, latency counter, owner, round-robin pointer and read address.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            latCnt  <= '0;
            owner   <= REQ_IF;
            lastGnt <= REQ_IF;
            addrQ   <= '0;
        end else begin
            state   <= stateNext;
            latCnt  <= latCntNext;
            owner   <= ownerNext;
            lastGnt <= lastGntNext;
            addrQ   <= addrQNext;
        end
    end

    // Next-state logic plus all requester and memory-port outputs.
    always_comb begin
        stateNext     = state;
        latCntNext    = latCnt;
        ownerNext     = owner;
        lastGntNext   = lastGnt;
        addrQNext     = addrQ;

        bus.if_gnt    = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = DATA_ZERO;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = DATA_ZERO;
        bus.mem_raddr = addrQ;
        bus.mem_waddr = addrQ;
        bus.mem_wdata = DATA_ZERO;
        bus.mem_wr    = 1'b0;

        if (reset) begin
            // Everything reads as zero while reset is held, including a
            // read that would otherwise be completing this cycle.
            bus.mem_raddr = ADDR_ZERO;
            bus.mem_waddr = ADDR_ZERO;
        end else begin
            if (state == RD_BUSY) begin
                latCntNext = latCnt - LAT_LAST;
                if (completing) begin
                    stateNext = IDLE;
                    if (owner == REQ_D) begin
                        bus.d_rvalid = 1'b1;
                        bus.d_rdata  = bus.mem_rdata;
                    end else begin
                        bus.if_rvalid = 1'b1;
                        bus.if_rdata  = bus.mem_rdata;
                    end
                end
            end

            if (gntIf || gntD) begin
                bus.if_gnt    = gntIf;
                bus.d_gnt     = gntD;
                bus.mem_raddr = selAddr;
                bus.mem_waddr = selAddr;
                lastGntNext   = gntD ? REQ_D : REQ_IF;
                if (isStore) begin
                    // Stores finish in the grant cycle; nothing to wait for.
                    bus.mem_wr    = 1'b1;
                    bus.mem_wdata = bus.d_wdata;
                end else begin
                    stateNext  = RD_BUSY;
                    latCntNext = LAT_LOAD;
                    ownerNext  = gntD ? REQ_D : REQ_IF;
                    addrQNext  = selAddr;
                end
            end
        end
    end

    // Structural invariants that must hold whenever reset is released.
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(bus.if_gnt && bus.d_gnt));
            assert (!(bus.if_rvalid && bus.d_rvalid));
            assert (!(bus.if_rvalid || bus.d_rvalid) || (state == RD_BUSY));
        end
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances at read latencies 1, 2 and 3,
// a transaction-level model checked every cycle, and directed literal
// expectations pinned to absolute cycles.
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    localparam int NI = 3;
    localparam int AW = 64;
    localparam int DW = 64;

    localparam int S_IFGNT = 0;
    localparam int S_DGNT  = 1;
    localparam int S_IFRV  = 2;
    localparam int S_DRV   = 3;
    localparam int S_IFRD  = 4;
    localparam int S_DRD   = 5;
    localparam int S_WR    = 6;
    localparam int S_WADDR = 7;
    localparam int S_RADDR = 8;
    localparam int S_WDATA = 9;

    typedef struct {
        int          cyc;
        int          inst;
        int          sig;
        logic [63:0] val;
    } lit_t;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- per-instance stimulus and observation ----------------
    logic          rst      [NI];
    logic          ifReq    [NI];
    logic [AW-1:0] ifAddr   [NI];
    logic          dReq     [NI];
    logic          dWe      [NI];
    logic [AW-1:0] dAddr    [NI];
    logic [DW-1:0] dWdata   [NI];
    logic [DW-1:0] memRdata [NI];

    logic          ifGnt    [NI];
    logic          dGnt     [NI];
    logic          ifRvalid [NI];
    logic          dRvalid  [NI];
    logic [DW-1:0] ifRdata  [NI];
    logic [DW-1:0] dRdata   [NI];
    logic          memWr    [NI];
    logic [AW-1:0] memWaddr [NI];
    logic [AW-1:0] memRaddr [NI];
    logic [DW-1:0] memWdata [NI];
    arb_state_t    dbg      [NI];

    // Memory read data is a known function of instance and cycle.
    function automatic logic [63:0] memPat(int k, int c);
        return {32'hA5A5_0000 + 32'(k), 32'(c)};
    endfunction

    always_comb begin
        for (int k = 0; k < NI; k++) memRdata[k] = memPat(k, cyc);
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

        assign bus.if_req    = ifReq[g];
        assign bus.if_addr   = ifAddr[g];
        assign bus.d_req     = dReq[g];
        assign bus.d_we      = dWe[g];
        assign bus.d_addr    = dAddr[g];
        assign bus.d_wdata   = dWdata[g];
        assign bus.mem_rdata = memRdata[g];

        assign ifGnt[g]    = bus.if_gnt;
        assign dGnt[g]     = bus.d_gnt;
        assign ifRvalid[g] = bus.if_rvalid;
        assign dRvalid[g]  = bus.d_rvalid;
        assign ifRdata[g]  = bus.if_rdata;
        assign dRdata[g]   = bus.d_rdata;
        assign memWr[g]    = bus.mem_wr;
        assign memWaddr[g] = bus.mem_waddr;
        assign memRaddr[g] = bus.mem_raddr;
        assign memWdata[g] = bus.mem_wdata;

        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(g + 1)) dut (
            .clock    (clock),
            .reset    (rst[g]),
            .bus      (bus.slave),
            .dbgState (dbg[g])
        );
    end

    // ---------------- scoreboard ----------------
    int   totalCnt = 0;
    int   badCnt   = 0;
    lit_t litQ[$];

    // Model state: is a read outstanding, when it completes, who owns it,
    // who was granted last (0 fetch / 1 data), last read address.
    logic        mBusy  [NI];
    int          mDue   [NI];
    int          mOwner [NI];
    int          mLast  [NI];
    logic [63:0] mAddrQ [NI];

    function automatic string sigName(int s);
        case (s)
            S_IFGNT: return "if_gnt";
            S_DGNT:  return "d_gnt";
            S_IFRV:  return "if_rvalid";
            S_DRV:   return "d_rvalid";
            S_IFRD:  return "if_rdata";
            S_DRD:   return "d_rdata";
            S_WR:    return "mem_wr";
            S_WADDR: return "mem_waddr";
            S_RADDR: return "mem_raddr";
            default: return "mem_wdata";
        endcase
    endfunction

    function automatic logic [63:0] obs(int k, int s);
        case (s)
            S_IFGNT: return 64'(ifGnt[k]);
            S_DGNT:  return 64'(dGnt[k]);
            S_IFRV:  return 64'(ifRvalid[k]);
            S_DRV:   return 64'(dRvalid[k]);
            S_IFRD:  return ifRdata[k];
            S_DRD:   return dRdata[k];
            S_WR:    return 64'(memWr[k]);
            S_WADDR: return memWaddr[k];
            S_RADDR: return memRaddr[k];
            default: return memWdata[k];
        endcase
    endfunction

    task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
        totalCnt++;
        if (act !== exp) begin
            badCnt++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
        end
    endtask

    // One cycle of the transaction-level model for instance k (latency k+1).
    task automatic modelStep(int k);
        logic        completing;
        logic        window;
        int          w;
        logic [63:0] exp [10];

        for (int s = 0; s < 10; s++) exp[s] = '0;
        completing = 1'b0;
        w = -1;
        if (!rst[k]) begin
            exp[S_WADDR] = mAddrQ[k];
            exp[S_RADDR] = mAddrQ[k];
            completing = mBusy[k] && (cyc == mDue[k]);
            window     = !mBusy[k] || completing;
            if (window) begin
                if (ifReq[k] && dReq[k]) w = (mLast[k] == 0) ? 1 : 0;
                else if (dReq[k])        w = 1;
                else if (ifReq[k])       w = 0;
            end
            if (completing) begin
                if (mOwner[k] == 1) begin
                    exp[S_DRV] = 64'd1;
                    exp[S_DRD] = memRdata[k];
                end else begin
                    exp[S_IFRV] = 64'd1;
                    exp[S_IFRD] = memRdata[k];
                end
            end
            if (w >= 0) begin
                exp[S_IFGNT] = 64'(w == 0);
                exp[S_DGNT]  = 64'(w == 1);
                exp[S_WADDR] = (w == 1) ? dAddr[k] : ifAddr[k];
                exp[S_RADDR] = exp[S_WADDR];
                if (w == 1 && dWe[k]) begin
                    exp[S_WR]    = 64'd1;
                    exp[S_WDATA] = dWdata[k];
                end
            end
        end

        for (int s = 0; s < 10; s++) chk(sigName(s), k, obs(k, s), exp[s]);

        if (rst[k]) begin
            mBusy[k]  = 1'b0;
            mDue[k]   = 0;
            mOwner[k] = 0;
            mLast[k]  = 0;
            mAddrQ[k] = '0;
        end else begin
            if (completing) mBusy[k] = 1'b0;
            if (w >= 0) begin
                mLast[k] = w;
                if (!(w == 1 && dWe[k])) begin
                    mBusy[k]  = 1'b1;
                    mDue[k]   = cyc + k + 1;
                    mOwner[k] = w;
                    mAddrQ[k] = exp[S_RADDR];
                end
            end
        end
    endtask

    // Single compare process: model check on every instance, then any
    // literal expectations due this cycle.
    always @(negedge clock) begin
        for (int k = 0; k < NI; k++) modelStep(k);
        for (int i = litQ.size() - 1; i >= 0; i--) begin
            if (litQ[i].cyc == cyc) begin
                chk({"lit_", sigName(litQ[i].sig)}, litQ[i].inst,
                    obs(litQ[i].inst, litQ[i].sig), litQ[i].val);
                litQ.delete(i);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic expectLit(int c, int k, int s, logic [63:0] v);
        lit_t e;
        e.cyc = c; e.inst = k; e.sig = s; e.val = v;
        litQ.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) next();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int c0;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; ifReq[k] = 1'b0; ifAddr[k] = '0;
            dReq[k] = 1'b0; dWe[k] = 1'b0; dAddr[k] = '0; dWdata[k] = '0;
        end
        idle(3);
        c0 = cyc;
        for (int k = 0; k < NI; k++) begin
            expectLit(c0, k, S_IFGNT, 64'd0);
            expectLit(c0, k, S_RADDR, 64'd0);
        end
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        idle(2);

        // Contested first requests, latency 1: data wins, fetch follows.
        c0 = cyc;
        ifReq[0] = 1'b1; ifAddr[0] = 64'h200;
        dReq[0]  = 1'b1; dWe[0] = 1'b0; dAddr[0] = 64'h100;
        expectLit(c0,     0, S_DGNT,  64'd1);
        expectLit(c0,     0, S_IFGNT, 64'd0);
        expectLit(c0,     0, S_RADDR, 64'h100);
        expectLit(c0 + 1, 0, S_IFGNT, 64'd1);
        expectLit(c0 + 1, 0, S_DRV,   64'd1);
        expectLit(c0 + 1, 0, S_DRD,   memPat(0, c0 + 1));
        expectLit(c0 + 1, 0, S_RADDR, 64'h200);
        expectLit(c0 + 2, 0, S_IFRV,  64'd1);
        expectLit(c0 + 2, 0, S_IFRD,  memPat(0, c0 + 2));
        expectLit(c0 + 2, 0, S_DRV,   64'd0);
        next(); dReq[0] = 1'b0;
        next(); ifReq[0] = 1'b0;
        idle(3);

        // Streaming fetches, latency 2: one grant every two cycles.
        c0 = cyc;
        ifReq[1] = 1'b1; ifAddr[1] = 64'h0;
        expectLit(c0,     1, S_IFGNT, 64'd1);
        expectLit(c0 + 1, 1, S_IFGNT, 64'd0);
        expectLit(c0 + 1, 1, S_IFRD,  64'd0);
        expectLit(c0 + 2, 1, S_IFGNT, 64'd1);
        expectLit(c0 + 2, 1, S_IFRV,  64'd1);
        expectLit(c0 + 2, 1, S_IFRD,  memPat(1, c0 + 2));
        expectLit(c0 + 2, 1, S_RADDR, 64'h4);
        expectLit(c0 + 3, 1, S_IFRV,  64'd0);
        expectLit(c0 + 3, 1, S_IFRD,  64'd0);
        expectLit(c0 + 4, 1, S_IFGNT, 64'd1);
        expectLit(c0 + 4, 1, S_IFRV,  64'd1);
        expectLit(c0 + 6, 1, S_IFRV,  64'd1);
        expectLit(c0 + 6, 1, S_IFRD,  memPat(1, c0 + 6));
        next(); ifAddr[1] = 64'h4;
        idle(2); ifAddr[1] = 64'h8;
        idle(2); ifReq[1] = 1'b0;
        idle(4);

        // Back-to-back stores: granted every cycle, no read data.
        c0 = cyc;
        dReq[1] = 1'b1; dWe[1] = 1'b1; dAddr[1] = 64'h20; dWdata[1] = 64'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            expectLit(c0 + i, 1, S_DGNT,  64'd1);
            expectLit(c0 + i, 1, S_WR,    64'd1);
            expectLit(c0 + i, 1, S_WADDR, 64'h20);
            expectLit(c0 + i, 1, S_WDATA, 64'hDEADBEEF);
            expectLit(c0 + i + 1, 1, S_DRV, 64'd0);
        end
        expectLit(c0 + 3, 1, S_WR,    64'd0);
        expectLit(c0 + 3, 1, S_WADDR, 64'h8);
        idle(3); dReq[1] = 1'b0; dWe[1] = 1'b0;
        idle(3);

        // Reset during a latency-3 read; the pending rvalid never appears.
        c0 = cyc;
        ifReq[2] = 1'b1; ifAddr[2] = 64'h300;
        expectLit(c0,     2, S_IFGNT, 64'd1);
        expectLit(c0 + 1, 2, S_RADDR, 64'd0);
        expectLit(c0 + 2, 2, S_IFRV,  64'd0);
        expectLit(c0 + 3, 2, S_IFRV,  64'd0);
        expectLit(c0 + 3, 2, S_RADDR, 64'd0);
        next(); ifReq[2] = 1'b0; rst[2] = 1'b1;
        next(); rst[2] = 1'b0;
        idle(2);
        // Contested after reset: data first, fetch at its completing cycle.
        ifReq[2] = 1'b1; ifAddr[2] = 64'h310;
        dReq[2]  = 1'b1; dWe[2] = 1'b0; dAddr[2] = 64'h320;
        expectLit(c0 + 4,  2, S_DGNT,  64'd1);
        expectLit(c0 + 4,  2, S_IFGNT, 64'd0);
        expectLit(c0 + 7,  2, S_IFGNT, 64'd1);
        expectLit(c0 + 7,  2, S_DRV,   64'd1);
        expectLit(c0 + 7,  2, S_DRD,   memPat(2, c0 + 7));
        expectLit(c0 + 10, 2, S_IFRV,  64'd1);
        next(); dReq[2] = 1'b0;
        idle(3); ifReq[2] = 1'b0;
        idle(5);

        // Data request raised during a latency-2 fetch: granted on completion.
        c0 = cyc;
        ifReq[1] = 1'b1; ifAddr[1] = 64'h50;
        expectLit(c0 + 1, 1, S_DGNT,  64'd0);
        expectLit(c0 + 2, 1, S_DGNT,  64'd1);
        expectLit(c0 + 2, 1, S_IFRV,  64'd1);
        expectLit(c0 + 2, 1, S_RADDR, 64'h40);
        expectLit(c0 + 3, 1, S_DRV,   64'd0);
        expectLit(c0 + 4, 1, S_DRV,   64'd1);
        expectLit(c0 + 4, 1, S_DRD,   memPat(1, c0 + 4));
        next(); ifReq[1] = 1'b0; dReq[1] = 1'b1; dWe[1] = 1'b0; dAddr[1] = 64'h40;
        idle(2); dReq[1] = 1'b0;
        idle(5);

        if (litQ.size() != 0) begin
            $display("FAIL lit_pending count=%0d want=0", litQ.size());
        end
        $display("test done: total=%0d bad=%0d", totalCnt, badCnt + litQ.size());
        $finish;
    end

endmodule : tb_mem_port_arbiter
